// File: rtl/pito_pkg.sv
// pito shared types and constants.
// Program loader states and frame field sizes.
package pito_pkg;

  typedef enum logic [2:0] {
    LD_HDR,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } loader_state_e;

  localparam int LD_HDR_BYTES  = 4;
  localparam int LD_WORD_BYTES = 4;

endpackage

// File: rtl/pito_prog_loader_if.sv
// Byte stream valid/ready link into the program loader.
// The master drives bytes, the slave signals acceptance.
interface pito_prog_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/pito_byte_packer.sv
// Little-endian 4-byte assembler used for header and payload words.
// word/word_valid are combinational on the 4th byte.
module pito_byte_packer
  import pito_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  logic [23:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sh  <= '0;
    end else if (byte_valid) begin
      sh  <= {byte_in, sh[23:8]};
      cnt <= cnt + 2'd1;
    end
  end

  assign word = {byte_in, sh};
  assign word_valid = byte_valid &
    (cnt == 2'(LD_WORD_BYTES - 1));

endmodule

// File: rtl/pito_prog_loader.sv
// Framed program image loader: header N, N payload words, XOR checksum.
// Holds the core in reset until a checksum-valid image is in imem.
module pito_prog_loader
  import pito_pkg::*;
#(
  parameter  int IMEM_DEPTH = 4096,
  localparam int ADDR_W = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  pito_prog_loader_if.slave s,
  input  logic              load_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_e     state;
  logic              rdy;
  logic [ADDR_W:0]   n;
  logic [7:0]        xsum;
  logic              xfer;
  logic              pk_valid;
  logic              pk_clr;
  logic [31:0]       word;
  logic              word_valid;
  logic [ADDR_W:0]   nxt;

  assign s.in_ready = rdy;
  assign xfer = s.in_valid & rdy;
  assign pk_valid = xfer &
    (state == LD_HDR || state == LD_DATA);
  assign pk_clr = load_start &
    (state == LD_DONE || state == LD_ERR);
  assign nxt = words_loaded + 1'b1;

  pito_byte_packer u_pk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .byte_in    (s.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LD_HDR;
      rdy          <= 1'b0;
      n            <= '0;
      xsum         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LD_HDR: begin
          rdy <= 1'b1;
          if (word_valid) begin
            n <= word[ADDR_W:0];
            if (word > 32'(IMEM_DEPTH)) begin
              state    <= LD_ERR;
              rdy      <= 1'b0;
              load_err <= 1'b1;
            end else if (word == '0) begin
              state <= LD_CSUM;
            end else begin
              state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (xfer)
            xsum <= xsum ^ s.in_data;
          if (word_valid) begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= word;
            words_loaded <= nxt;
            if (nxt == n)
              state <= LD_CSUM;
          end
        end
        LD_CSUM: begin
          if (xfer) begin
            rdy <= 1'b0;
            if (s.in_data == xsum) begin
              state      <= LD_DONE;
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state    <= LD_ERR;
              load_err <= 1'b1;
            end
          end
        end
        LD_DONE, LD_ERR: begin
          if (load_start) begin
            state        <= LD_HDR;
            rdy          <= 1'b1;
            n            <= '0;
            xsum         <= '0;
            core_rst_n   <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
          end
        end
        default: begin
          state <= LD_HDR;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pito_prog_loader.sv
// Directed bench for pito_prog_loader with a small imem depth.
// Table-driven frames plus hand sequences for size limits and reset.
module tb_pito_prog_loader;

  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pito_prog_loader_if bif ();

  pito_prog_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (bif),
    .load_start   (load_start),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  always @(negedge clk)
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end

  typedef struct {
    int          n;
    logic [31:0] w[4];
    logic [7:0]  csum;
    bit          ok;
    int          maxgap;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bif.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bif.in_data = b;
    bif.in_valid = 1'b1;
    t = 0;
    while (!bif.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      ncomp++;
      nfail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
      bif.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 bif.in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], $urandom_range(0, maxgap));
  endtask

  function automatic logic [7:0] xor_of(input logic [31:0] ws[$]);
    logic [7:0] x = 8'h00;
    foreach (ws[i])
      x ^= ws[i][31:24] ^ ws[i][23:16] ^ ws[i][15:8] ^ ws[i][7:0];
    return x;
  endfunction

  task automatic rearm();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("rearm_done", 32'(load_done), 32'd0);
    chk("rearm_err", 32'(load_err), 32'd0);
    chk("rearm_words", 32'(words_loaded), 32'd0);
    chk("rearm_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rearm_in_ready", 32'(bif.in_ready), 32'd1);
  endtask

  task automatic check_end(input string tag, input bit ok,
                           input logic [31:0] ws[$]);
    chk({tag, "_done"}, 32'(load_done), 32'(ok));
    chk({tag, "_err"}, 32'(load_err), 32'(!ok));
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(ok));
    chk({tag, "_in_ready"}, 32'(bif.in_ready), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(ws.size()));
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(ws.size()));
    foreach (ws[i])
      if (i < wa_q.size()) begin
        chk({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
        chk({tag, "_data"}, wd_q[i], ws[i]);
      end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] ws[$];
    for (int k = 0; k < v.n; k++) ws.push_back(v.w[k]);
    wa_q.delete();
    wd_q.delete();
    send_word(32'(v.n), v.maxgap);
    @(negedge clk);
    chk({tag, "_mid_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_mid_done"}, 32'(load_done), 32'd0);
    foreach (ws[i]) send_word(ws[i], v.maxgap);
    send_byte(v.csum, $urandom_range(0, v.maxgap));
    @(negedge clk);
    check_end(tag, v.ok, ws);
  endtask

  initial begin
    logic [31:0] ws[$];
    bif.in_data = 8'h00;
    bif.in_valid = 1'b0;

    // XOR of 0x00000013, 0xDEADBEEF, 0x12345678 bytes is 0x39
    vecs[0] = '{3, '{32'h00000013, 32'hDEADBEEF, 32'h12345678, 32'h0},
                8'h39, 1'b1, 0};
    vecs[1] = '{0, '{32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b1, 0};
    vecs[2] = '{0, '{32'h0, 32'h0, 32'h0, 32'h0}, 8'h01, 1'b0, 0};
    vecs[3] = '{2, '{32'h11111111, 32'h22222222, 32'h0, 32'h0},
                8'h01, 1'b0, 0};
    vecs[4] = '{3, '{32'h00000013, 32'hDEADBEEF, 32'h12345678, 32'h0},
                8'hA8, 1'b0, 0};
    vecs[5] = '{1, '{32'hA5A5A5A5, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b1, 0};
    vecs[6] = '{3, '{32'h00000013, 32'hDEADBEEF, 32'h12345678, 32'h0},
                8'h39, 1'b1, 5};

    #2;
    chk("rst_in_ready", 32'(bif.in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bif.in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      if (load_done || load_err) rearm();
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // oversize header goes straight to ERR
    rearm();
    wa_q.delete();
    wd_q.delete();
    send_word(32'(DEPTH + 1), 0);
    @(negedge clk);
    chk("over_err", 32'(load_err), 32'd1);
    chk("over_done", 32'(load_done), 32'd0);
    chk("over_in_ready", 32'(bif.in_ready), 32'd0);
    chk("over_core_rst_n", 32'(core_rst_n), 32'd0);
    repeat (3) @(negedge clk);
    chk("over_nwrites", 32'(wa_q.size()), 32'd0);

    // full-depth image, last word lands at DEPTH-1
    rearm();
    wa_q.delete();
    wd_q.delete();
    ws.delete();
    for (int k = 0; k < DEPTH; k++) ws.push_back(32'hC0DE0000 + 32'(k * 3));
    send_word(32'(DEPTH), 0);
    foreach (ws[i]) send_word(ws[i], 0);
    send_byte(xor_of(ws), 0);
    @(negedge clk);
    check_end("full", 1'b1, ws);

    // reset mid-payload then reload cleanly
    rearm();
    send_word(32'd3, 0);
    send_word(32'h00000013, 0);
    send_byte(8'hEF, 0);
    @(negedge clk);
    chk("mid_words_pre", 32'(words_loaded), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("mid_rst_words", 32'(words_loaded), 32'd0);
    chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("reload", vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncomp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
